// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// FSM state encoding, digit width and the output-width sizing function.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_e;

    // Smallest width able to hold 10^digits - 1, i.e. ceil(log2(10^digits)).
    function automatic int bcdBinWidth(input int digits);
        longint unsigned lim;
        int              w;
        lim = 1;
        for (int i = 0; i < digits; i++) begin
            lim = lim * 10;
        end
        w = 0;
        while ((64'd1 << w) < lim) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational fold step: result = acc*10 + digit, truncated to OUT_W,
// plus a flag for a digit above 9.
// Optional feature macro: BCD_DIGIT_CHECK_EN (enables the digit>9 comparator;
// without it the flag is tied low and out-of-range digits fold as-is).
module bcd_mac10
    import bcd_pkg::*;
#(
    parameter int OUT_W = 14
) (
    input  logic [OUT_W-1:0]   acc,
    input  logic [DIGIT_W-1:0] digit,
    output logic [OUT_W-1:0]   result,
    output logic               digit_err
);

    // Four guard bits hold acc*10 before truncation back to OUT_W.
    logic [OUT_W+3:0] acc_ext;
    logic [OUT_W+3:0] dig_ext;

    // Multiply by ten as (acc<<3)+(acc<<1), then add the incoming digit.
    always_comb begin
        acc_ext = {4'b0000, acc};
        dig_ext = (OUT_W + 4)'(digit);
        result  = OUT_W'((acc_ext << 3) + (acc_ext << 1) + dig_ext);
    end

`ifdef BCD_DIGIT_CHECK_EN
    assign digit_err = (digit > 4'd9);
`else
    assign digit_err = 1'b0;
`endif

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential multi-digit BCD-to-binary converter. Folds one BCD digit per
// clock (most significant first) with valid/ready handshakes on both sides.
// Optional feature macro: BCD_DIGIT_CHECK_EN (digit>9 detection; a flagged
// word reports errOut=1 with binOut forced to 0).
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 14
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic [DIGIT_W*DIGITS-1:0] bcdIn,
    input  logic                    inValid,
    output logic                    inReady,
    output logic [OUT_W-1:0]        binOut,
    output logic                    outValid,
    input  logic                    outReady,
    output logic                    errOut
);

    localparam int IN_W  = DIGIT_W * DIGITS;
    localparam int CNT_W = 4;

    if (DIGITS < 1 || DIGITS > 9) begin : g_bad_digits
        $error("bcd_to_bin_seq: DIGITS must be in 1..9");
    end
    if (OUT_W < bcdBinWidth(DIGITS)) begin : g_bad_out_w
        $error("bcd_to_bin_seq: OUT_W too narrow for DIGITS");
    end

    state_e             state_q, state_d;
    logic [IN_W-1:0]    sreg_q,  sreg_d;
    logic [OUT_W-1:0]   acc_q,   acc_d;
    logic [OUT_W-1:0]   bin_q,   bin_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               err_q,   err_d;

    logic [DIGIT_W-1:0] top_digit;
    logic [OUT_W-1:0]   mac_result;
    logic               digit_err;

    // The digit being folded is always the top nibble of the shift register.
    assign top_digit = sreg_q[IN_W-1 -: DIGIT_W];

    bcd_mac10 #(
        .OUT_W (OUT_W)
    ) u_mac10 (
        .acc       (acc_q),
        .digit     (top_digit),
        .result    (mac_result),
        .digit_err (digit_err)
    );

    // Next-state and datapath updates for the IDLE -> CONV -> DONE sequence.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        acc_d   = acc_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (inValid) begin
                    sreg_d  = bcdIn;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(DIGITS - 1);
                    err_d   = 1'b0;
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d  = mac_result;
                sreg_d = sreg_q << DIGIT_W;
                cnt_d  = cnt_q - CNT_W'(1);
                err_d  = err_q | digit_err;
                if (cnt_q == '0) begin
                    // A flagged word never exposes its partial arithmetic.
                    bin_d   = (err_q | digit_err) ? '0 : mac_result;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (outReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any word in flight.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            acc_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            acc_q   <= acc_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign inReady  = (state_q == IDLE);
    assign outValid = (state_q == DONE);
    assign binOut   = bin_q;
    assign errOut   = outValid & err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
module tb_bcd_to_bin_seq;

    typedef struct packed {
        logic [2:0]  sel;
        logic        e;
        logic [19:0] val;
    } exp_t;

    logic clk  = 1'b0;
    logic rstN = 1'b1;
    always #5 clk = ~clk;

    // Index map: 0 -> DIGITS=1, 1 -> 2, 2 -> 3, 3 -> 4, 4 -> 6
    logic [23:0] bcd  [5];
    logic        vld  [5];
    logic        ordy [5];
    logic        rdy  [5];
    logic        ov   [5];
    logic        eo   [5];
    logic [3:0]  bo1;
    logic [6:0]  bo2;
    logic [9:0]  bo3;
    logic [13:0] bo4;
    logic [19:0] bo6;

    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   done   = 0;
    exp_t sbq [$];
    exp_t me;

    bcd_to_bin_seq #(.DIGITS(1), .OUT_W(4)) u1 (
        .clk(clk), .rstN(rstN), .bcdIn(bcd[0][3:0]), .inValid(vld[0]), .inReady(rdy[0]),
        .binOut(bo1), .outValid(ov[0]), .outReady(ordy[0]), .errOut(eo[0]));
    bcd_to_bin_seq #(.DIGITS(2), .OUT_W(7)) u2 (
        .clk(clk), .rstN(rstN), .bcdIn(bcd[1][7:0]), .inValid(vld[1]), .inReady(rdy[1]),
        .binOut(bo2), .outValid(ov[1]), .outReady(ordy[1]), .errOut(eo[1]));
    bcd_to_bin_seq #(.DIGITS(3), .OUT_W(10)) u3 (
        .clk(clk), .rstN(rstN), .bcdIn(bcd[2][11:0]), .inValid(vld[2]), .inReady(rdy[2]),
        .binOut(bo3), .outValid(ov[2]), .outReady(ordy[2]), .errOut(eo[2]));
    bcd_to_bin_seq #(.DIGITS(4), .OUT_W(14)) u4 (
        .clk(clk), .rstN(rstN), .bcdIn(bcd[3][15:0]), .inValid(vld[3]), .inReady(rdy[3]),
        .binOut(bo4), .outValid(ov[3]), .outReady(ordy[3]), .errOut(eo[3]));
    bcd_to_bin_seq #(.DIGITS(6), .OUT_W(20)) u6 (
        .clk(clk), .rstN(rstN), .bcdIn(bcd[4][23:0]), .inValid(vld[4]), .inReady(rdy[4]),
        .binOut(bo6), .outValid(ov[4]), .outReady(ordy[4]), .errOut(eo[4]));

    function automatic int digs(input int k);
        case (k)
            0: return 1;
            1: return 2;
            2: return 3;
            3: return 4;
            default: return 6;
        endcase
    endfunction

    function automatic int ow(input int k);
        case (k)
            0: return 4;
            1: return 7;
            2: return 10;
            3: return 14;
            default: return 20;
        endcase
    endfunction

    function automatic logic [19:0] bo_of(input int k);
        case (k)
            0: return 20'(bo1);
            1: return 20'(bo2);
            2: return 20'(bo3);
            3: return 20'(bo4);
            default: return bo6;
        endcase
    endfunction

    // Decimal reference: sum of digit * 10^position, reduced modulo 2^OUT_W.
    function automatic exp_t model(input int k, input logic [23:0] w);
        exp_t        r;
        longint      acc;
        longint      pw;
        logic        bad;
        logic [3:0]  d;
        acc = 0;
        pw  = 1;
        bad = 1'b0;
        for (int i = 0; i < digs(k); i++) begin
            d   = w[4*i +: 4];
            acc = acc + longint'(d) * pw;
            pw  = pw * 10;
            if (d > 4'd9) bad = 1'b1;
        end
        acc = acc & ((longint'(1) << ow(k)) - 1);
`ifdef BCD_DIGIT_CHECK_EN
        if (bad) acc = 0;
        r.e = bad;
`else
        r.e = 1'b0;
`endif
        r.sel = 3'(k);
        r.val = 20'(acc);
        return r;
    endfunction

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: a transfer happens at the next rising edge
    // whenever outValid and outReady are both high.
    always @(negedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (rstN && ov[k] && ordy[k]) begin
                done++;
                chk("sb_nonempty", longint'(sbq.size() != 0), 1);
                if (sbq.size() != 0) begin
                    me = sbq.pop_front();
                    chk("out_sel", k, me.sel);
                    chk("binOut", bo_of(k), me.val);
                    chk("errOut", eo[k], me.e);
                end
            end
        end
    end

    // Present a word and hold inValid until it is accepted (bounded).
    task automatic send(input int k, input logic [23:0] w);
        bit got;
        got    = 1'b0;
        bcd[k] = w;
        vld[k] = 1'b1;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (rdy[k]) begin
                @(posedge clk);
                got = 1'b1;
            end
        end
        if (got) begin
            sbq.push_back(model(k, w));
            pushed++;
        end
        #1 vld[k] = 1'b0;
        chk("accept", got, 1);
    endtask

    // Wait for the scoreboard to drain, optionally randomising outReady.
    task automatic wait_done(input int k, input bit rnd);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (sbq.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (rnd) ordy[k] = 1'($urandom_range(0, 1));
        end
        chk("complete", ok, 1);
    endtask

    initial begin
        logic [23:0] w;
        bit          seen;
        for (int k = 0; k < 5; k++) begin
            bcd[k]  = '0;
            vld[k]  = 1'b0;
            ordy[k] = 1'b0;
        end

        // Reset state
        #2 rstN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ov", ov[3], 0);
        chk("rst_bin", bo_of(3), 0);
        chk("rst_err", eo[3], 0);
        @(negedge clk) rstN = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rdy", rdy[3], 1);

        // 0x1234 with latency and return-to-idle timing
        for (int k = 0; k < 5; k++) ordy[k] = 1'b1;
        send(3, 24'h1234);
        repeat (3) @(posedge clk);
        #1;
        chk("lat_before", ov[3], 0);
        chk("busy_rdy", rdy[3], 0);
        @(posedge clk);
        #1;
        chk("lat_at", ov[3], 1);
        chk("bin_1234", bo_of(3), 1234);
        chk("err_1234", eo[3], 0);
        @(posedge clk);
        #1;
        chk("idle_rdy", rdy[3], 1);
        chk("idle_ov", ov[3], 0);

        // Boundary values
        send(3, 24'h9999); wait_done(3, 1'b0);
        send(3, 24'h0000); wait_done(3, 1'b0);
        send(1, 24'h99);   wait_done(1, 1'b0);
        send(0, 24'h7);
        @(posedge clk);
        #1;
        chk("d1_lat", ov[0], 1);
        chk("d1_bin", bo_of(0), 7);
        wait_done(0, 1'b0);

        // Out-of-range digit
        send(3, 24'h12A4); wait_done(3, 1'b0);

        // Backpressure with a dropped second request
        ordy[3] = 1'b0;
        send(3, 24'h0042);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (ov[3]) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("bp_seen", seen, 1);
        for (int c = 0; c < 5; c++) begin
            chk("bp_ov", ov[3], 1);
            chk("bp_bin", bo_of(3), 42);
            chk("bp_rdy", rdy[3], 0);
            if (c == 1) begin
                bcd[3] = 24'h0777;
                vld[3] = 1'b1;
            end
            if (c == 3) vld[3] = 1'b0;
            @(posedge clk);
            #1;
        end
        ordy[3] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_released", ov[3], 0);
        chk("bp_idle", rdy[3], 1);
        repeat (6) @(posedge clk);
        #1;
        chk("bp_no_ghost", ov[3], 0);
        chk("bp_sb_empty", sbq.size(), 0);

        // Asynchronous reset in the middle of a conversion
        send(3, 24'h5678);
        repeat (2) @(posedge clk);
        #1 rstN = 1'b0;
        #1;
        chk("arst_ov", ov[3], 0);
        chk("arst_bin", bo_of(3), 0);
        sbq.delete();
        pushed--;
        repeat (2) @(posedge clk);
        @(negedge clk) rstN = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_rdy", rdy[3], 1);
        send(3, 24'h0001); wait_done(3, 1'b0);

        // Random legal words with random outReady gaps
        for (int s = 0; s < 4; s++) begin
            int k;
            k = (s == 0) ? 0 : (s == 1) ? 2 : (s == 2) ? 3 : 4;
            for (int n = 0; n < 8; n++) begin
                w = '0;
                for (int i = 0; i < digs(k); i++) w[4*i +: 4] = 4'($urandom_range(0, 9));
                send(k, w);
                wait_done(k, 1'b1);
            end
            ordy[k] = 1'b1;
        end

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", sbq.size(), 0);
        chk("done_count", done, pushed);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
